arbitro_clases_dest: RTL and testbench

//  Weighted round-robin scheduler between the two class FIFOs (class 0, class 1)

---
 rtl/arbitro_pkg.sv | 16 +
 rtl/arbitro_clases_dest_elig_clase.sv | 13 +
 rtl/arbitro_clases_dest.sv | 133 +++++++++++++
 tb/tb_arbitro_clases_dest.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared constants for the class scheduler, the destination demux and the FIFOs.
// Holds the FSM state encoding and a helper that maps a class to its owner state.
package arbitro_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned DEST_BIT_DEF = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  function automatic logic [1:0] own_state(input logic cls);
    return cls ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/arbitro_clases_dest_elig_clase.sv
// Eligibility of one class FIFO: it must be non-empty, and the destination
// FIFO targeted by its head word must not be almost-full.
module elig_clase (
  input  logic empty,
  input  logic dest,
  input  logic dest0_afull,
  input  logic dest1_afull,
  output logic elig_c
);

  assign elig_c = !empty && !(dest ? dest1_afull : dest0_afull);

endmodule

// File: rtl/arbitro_clases_dest.sv
// Weighted round-robin scheduler between two class FIFOs feeding one destination
// demux. Mealy pop outputs, registered word/destination/class outputs.
module arbitro_clases_dest
  import arbitro_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEST_BIT = DEST_BIT_DEF,
  parameter int unsigned W0       = 2,
  parameter int unsigned W1       = 1,
  parameter int unsigned CNT_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo0_empty,
  input  logic [DATA_W-1:0] fifo0_data,
  input  logic              fifo1_empty,
  input  logic [DATA_W-1:0] fifo1_data,
  input  logic              dest0_afull,
  input  logic              dest1_afull,
  output logic              pop0,
  output logic              pop1,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              dest_out,
  output logic              class_out
);

  localparam logic [CNT_W-1:0] W0_C  = CNT_W'(W0);
  localparam logic [CNT_W-1:0] W1_C  = CNT_W'(W1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  next_cnt;
  logic              elig0;
  logic              elig1;
  logic [DATA_W-1:0] sel_data;

  elig_clase u_elig0 (
    .empty       (fifo0_empty),
    .dest        (fifo0_data[DEST_BIT]),
    .dest0_afull (dest0_afull),
    .dest1_afull (dest1_afull),
    .elig_c      (elig0)
  );

  elig_clase u_elig1 (
    .empty       (fifo1_empty),
    .dest        (fifo1_data[DEST_BIT]),
    .dest0_afull (dest0_afull),
    .dest1_afull (dest1_afull),
    .elig_c      (elig1)
  );

  // Grant decision: owner keeps the grant until its weight is used up, unless the
  // other class is not eligible; a blocked owner hands over immediately.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    pop0       = 1'b0;
    pop1       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (elig0) begin
            pop0       = 1'b1;
            next_state = own_state(1'b0);
            next_cnt   = ONE_C;
          end else if (elig1) begin
            pop1       = 1'b1;
            next_state = own_state(1'b1);
            next_cnt   = ONE_C;
          end
        end
        OWN0: begin
          if (elig0 && ((cnt < W0_C) || !elig1)) begin
            pop0     = 1'b1;
            next_cnt = (cnt < W0_C) ? cnt + ONE_C : W0_C;
          end else if (elig1) begin
            pop1       = 1'b1;
            next_state = OWN1;
            next_cnt   = ONE_C;
          end else begin
            next_state = IDLE;
            next_cnt   = '0;
          end
        end
        OWN1: begin
          if (elig1 && ((cnt < W1_C) || !elig0)) begin
            pop1     = 1'b1;
            next_cnt = (cnt < W1_C) ? cnt + ONE_C : W1_C;
          end else if (elig0) begin
            pop0       = 1'b1;
            next_state = OWN0;
            next_cnt   = ONE_C;
          end else begin
            next_state = IDLE;
            next_cnt   = '0;
          end
        end
        default: begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  assign sel_data = pop1 ? fifo1_data : fifo0_data;

  // State, counter and output stage; outputs hold their last word when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      dest_out  <= 1'b0;
      class_out <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      valid_out <= pop0 | pop1;
      if (pop0 | pop1) begin
        data_out  <= sel_data;
        dest_out  <= sel_data[DEST_BIT];
        class_out <= pop1;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_clases_dest.sv
// Directed bench for arbitro_clases_dest: queue-based class FIFOs, a grant/run
// model checked every cycle, plus literal expectations for each scenario.
module tb_arbitro_clases_dest;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DEST_BIT = 4;
  localparam int unsigned W0       = 2;
  localparam int unsigned W1       = 1;
  localparam int unsigned CNT_W    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fifo0_empty, fifo1_empty;
  logic [DATA_W-1:0] fifo0_data, fifo1_data;
  logic              dest0_afull = 1'b0, dest1_afull = 1'b0;
  logic              pop0, pop1, valid_out, dest_out, class_out;
  logic [DATA_W-1:0] data_out;

  always #5 clk = ~clk;

  arbitro_clases_dest #(
    .DATA_W(DATA_W), .DEST_BIT(DEST_BIT), .W0(W0), .W1(W1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .fifo0_empty(fifo0_empty), .fifo0_data(fifo0_data),
    .fifo1_empty(fifo1_empty), .fifo1_data(fifo1_data),
    .dest0_afull(dest0_afull), .dest1_afull(dest1_afull),
    .pop0(pop0), .pop1(pop1), .valid_out(valid_out), .data_out(data_out),
    .dest_out(dest_out), .class_out(class_out)
  );

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] seen_data[$];
  int                seen_cls[$];
  int                seen_dest[$];
  int                pop_log[$];

  int checks = 0;
  int failures = 0;

  // Model: current owner (-1 none), length of its current run, expected outputs
  int                m_owner = -1;
  int                m_run = 0;
  bit                m_known = 1'b0;
  bit                m_valid = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  bit                m_dest = 1'b0;
  bit                m_cls = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    fifo0_empty = (q0.size() == 0);
    fifo0_data  = (q0.size() != 0) ? q0[0] : '0;
    fifo1_empty = (q1.size() == 0);
    fifo1_data  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  function automatic bit eligible(input bit nonempty, input logic [DATA_W-1:0] head);
    logic hd;
    hd = head[DEST_BIT];
    return nonempty && !(hd ? dest1_afull : dest0_afull);
  endfunction

  // One clock: check outputs and pops at negedge, advance model, pop queues after edge
  task automatic cycle();
    bit e[2];
    int w[2];
    int g;
    int k;
    int o;
    w[0] = W0;
    w[1] = W1;
    @(negedge clk);
    if (m_known) begin
      chk("valid_out", valid_out, m_valid);
      chk("data_out", data_out, m_data);
      chk("dest_out", dest_out, m_dest);
      chk("class_out", class_out, m_cls);
    end
    if (valid_out === 1'b1) begin
      seen_data.push_back(data_out);
      seen_cls.push_back(int'(class_out));
      seen_dest.push_back(int'(dest_out));
    end
    e[0] = eligible(q0.size() != 0, (q0.size() != 0) ? q0[0] : '0);
    e[1] = eligible(q1.size() != 0, (q1.size() != 0) ? q1[0] : '0);
    g = -1;
    if (!reset) begin
      if (m_owner < 0) begin
        if (e[0]) g = 0;
        else if (e[1]) g = 1;
      end else begin
        k = m_owner;
        o = 1 - k;
        if (e[k] && (m_run < w[k] || !e[o])) g = k;
        else if (e[o]) g = o;
      end
    end
    chk("pop0", pop0, 32'(g == 0));
    chk("pop1", pop1, 32'(g == 1));
    pop_log.push_back(g);
    if (reset) begin
      m_owner = -1; m_run = 0; m_known = 1'b1;
      m_valid = 1'b0; m_data = '0; m_dest = 1'b0; m_cls = 1'b0;
    end else if (g < 0) begin
      m_owner = -1; m_run = 0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      m_data  = (g == 0) ? q0[0] : q1[0];
      m_dest  = m_data[DEST_BIT];
      m_cls   = (g == 1);
      if (g == m_owner) m_run = (m_run + 1 < w[g]) ? m_run + 1 : w[g];
      else begin m_owner = g; m_run = 1; end
    end
    @(posedge clk);
    #1;
    if (g == 0) void'(q0.pop_front());
    if (g == 1) void'(q1.pop_front());
    drive();
  endtask

  task automatic flush();
    q0.delete(); q1.delete(); drive();
    repeat (2) cycle();
  endtask

  initial begin
    bit found;
    int n;
    // 1: reset held two cycles with both FIFOs loaded
    q0 = '{8'h20, 8'h21};
    q1 = '{8'h30};
    drive();
    repeat (2) cycle();
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_dest", dest_out, 0);
    chk("rst_class", class_out, 0);
    chk("rst_pop0", pop0, 0);
    chk("rst_pop1", pop1, 0);
    q0.delete(); q1.delete();
    reset = 1'b0;
    drive();

    // 2: only class 0 loaded
    q0 = '{8'h10, 8'h03, 8'h15};
    drive();
    pop_log.delete(); seen_data.delete(); seen_dest.delete();
    repeat (5) cycle();
    chk("t2_pop_a", pop_log[0], 0);
    chk("t2_pop_b", pop_log[1], 0);
    chk("t2_pop_c", pop_log[2], 0);
    chk("t2_pop_none", pop_log[3], 32'(-1));
    chk("t2_count", seen_data.size(), 3);
    if (seen_data.size() == 3) begin
      chk("t2_d0", seen_data[0], 8'h10);
      chk("t2_d1", seen_data[1], 8'h03);
      chk("t2_d2", seen_data[2], 8'h15);
      chk("t2_dest0", seen_dest[0], 1);
      chk("t2_dest1", seen_dest[1], 0);
      chk("t2_dest2", seen_dest[2], 1);
    end

    // 3: both classes backlogged, weights 2:1
    for (int i = 0; i < 8; i++) begin
      q0.push_back(8'(8'h40 + i));
      q1.push_back(8'(8'h50 + i));
    end
    drive();
    pop_log.delete(); seen_cls.delete();
    repeat (7) cycle();
    for (int i = 0; i < 6; i++) begin
      chk("t3_grant", pop_log[i], (i % 3 == 2) ? 1 : 0);
      chk("t3_class", seen_cls[i], (i % 3 == 2) ? 1 : 0);
    end
    flush();

    // 4: class-0 head blocked by dest1 almost-full
    q0 = '{8'h12};
    q1 = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    dest1_afull = 1'b1;
    drive();
    pop_log.delete();
    repeat (3) cycle();
    for (int i = 0; i < 3; i++) chk("t4_blocked", pop_log[i], 1);
    dest1_afull = 1'b0;
    drive();
    pop_log.delete(); seen_data.delete();
    repeat (3) cycle();
    found = 1'b0;
    for (int i = 0; i < 2; i++) if (pop_log[i] == 0) found = 1'b1;
    chk("t4_unblock", 32'(found), 1);
    found = 1'b0;
    foreach (seen_data[i]) if (seen_data[i] == 8'h12) found = 1'b1;
    chk("t4_seen12", 32'(found), 1);
    flush();

    // 5: reset right after popping 0x07 from class 1
    q1 = '{8'h07, 8'h08};
    drive();
    pop_log.delete();
    cycle();
    chk("t5_pop07", pop_log[0], 1);
    reset = 1'b1;
    drive();
    cycle();
    reset = 1'b0;
    q0 = '{8'h09};
    drive();
    seen_data.delete(); pop_log.delete();
    chk("t5_idle", 32'(dut.state), 0);
    chk("t5_valid", valid_out, 0);
    repeat (3) cycle();
    chk("t5_first_grant", pop_log[0], 0);
    found = 1'b0;
    foreach (seen_data[i]) if (seen_data[i] == 8'h07) found = 1'b1;
    chk("t5_no07", 32'(found), 0);
    flush();

    // 6: drain to empty, then refill class 1
    q0 = '{8'h22, 8'h23};
    drive();
    repeat (3) cycle();
    cycle();
    chk("t6_valid0", valid_out, 0);
    chk("t6_idle", 32'(dut.state), 0);
    q1 = '{8'h31};
    drive();
    pop_log.delete(); seen_data.delete(); seen_cls.delete();
    cycle();
    chk("t6_refill_pop", pop_log[0], 1);
    cycle();
    n = seen_data.size();
    chk("t6_seen_n", n, 1);
    if (n == 1) begin
      chk("t6_data", seen_data[0], 8'h31);
      chk("t6_class", seen_cls[0], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
